// File: rtl/vga_timing_generator.sv
// ---------------------------------------------------------------------------
// vga_timing_generator
//
// Purpose:
//   Parametrised VGA/SVGA raster timing generator. An internal divider turns
//   the system clock into a pixel-rate tick. Horizontal and vertical counters
//   advance on that tick. Sync, active-video, pixel coordinates and
//   line/frame start strobes are decoded from those counters. Sync polarity
//   is selectable, and a run enable freezes the whole raster in place.
//
// Ports:
//   CLK          in   1   system clock, rising edge
//   RST_N        in   1   asynchronous active-low reset
//   EN           in   1   run enable; low freezes timing and silences strobes
//   PIX_TICK     out  1   one-CLK strobe, pixel advance
//   VGA_HS       out  1   horizontal sync, asserted level = H_POL
//   VGA_VS       out  1   vertical sync, asserted level = V_POL
//   VGA_ENABLE   out  1   current pixel is inside the visible area
//   VGA_POS_X    out  XW  visible column, 0 outside the visible area
//   VGA_POS_Y    out  YW  visible row, 0 outside the visible area
//   LINE_START   out  1   one-CLK strobe when the column counter enters 0
//   FRAME_START  out  1   one-CLK strobe when the raster enters (0,0)
// ---------------------------------------------------------------------------
module vga_timing_generator #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter int H_POL    = 1,
    parameter int V_POL    = 1,
    parameter int CLK_DIV  = 2,
    parameter int XW       = 11,
    parameter int YW       = 10
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          EN,
    output logic          PIX_TICK,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_ENABLE,
    output logic [XW-1:0] VGA_POS_X,
    output logic [YW-1:0] VGA_POS_Y,
    output logic          LINE_START,
    output logic          FRAME_START
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);

    // Window bounds are one bit wider than the counters: with a zero back
    // porch the sync end equals the total, which may be exactly 2**XW.
    localparam logic [XW:0] H_ACT_END  = (XW+1)'(H_ACTIVE);
    localparam logic [XW:0] H_SYNC_BEG = (XW+1)'(H_ACTIVE + H_FP);
    localparam logic [XW:0] H_SYNC_END = (XW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW:0] V_ACT_END  = (YW+1)'(V_ACTIVE);
    localparam logic [YW:0] V_SYNC_BEG = (YW+1)'(V_ACTIVE + V_FP);
    localparam logic [YW:0] V_SYNC_END = (YW+1)'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic H_ON = (H_POL != 0);
    localparam logic V_ON = (V_POL != 0);

    // Reject parameter sets that cannot produce a sensible raster.
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_generator: CLK_DIV must be >= 1");
    end
    if (H_TOTAL > (2 ** XW)) begin : g_bad_xw
        $error("vga_timing_generator: H_TOTAL does not fit in XW bits");
    end
    if (V_TOTAL > (2 ** YW)) begin : g_bad_yw
        $error("vga_timing_generator: V_TOTAL does not fit in YW bits");
    end
    if (H_SYNC == 0 || V_SYNC == 0) begin : g_bad_sync
        $error("vga_timing_generator: sync widths must be non-zero");
    end

    logic [DW-1:0] div_q,  div_d;
    logic [XW-1:0] hcnt_q, hcnt_d;
    logic [YW-1:0] vcnt_q, vcnt_d;
    logic          tick_q, hs_q, vs_q, act_q, ls_q, fs_q;
    logic [XW-1:0] posx_q;
    logic [YW-1:0] posy_q;

    logic wrap;
    logic hVis, vVis, hSync, vSync, act_d;

    // Next-state logic. All outputs are decoded from the *next* counter
    // values so that they change on the same edge that raises PIX_TICK.
    always_comb begin
        wrap   = EN && (div_q == DIV_LAST);
        div_d  = div_q;
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;

        if (EN) begin
            div_d = wrap ? '0 : div_q + 1'b1;
        end

        if (wrap) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end

        hVis  = {1'b0, hcnt_d} <  H_ACT_END;
        vVis  = {1'b0, vcnt_d} <  V_ACT_END;
        hSync = ({1'b0, hcnt_d} >= H_SYNC_BEG) && ({1'b0, hcnt_d} < H_SYNC_END);
        vSync = ({1'b0, vcnt_d} >= V_SYNC_BEG) && ({1'b0, vcnt_d} < V_SYNC_END);
        act_d = hVis && vVis;
    end

    // State and output registers. Counters start on the last raster position
    // so that the first tick after reset lands on (0,0). Level outputs only
    // update on a pixel tick, so they hold whenever EN is low; strobes follow
    // the tick and therefore drop to 0 while EN is low.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div_q  <= '0;
            hcnt_q <= H_LAST;
            vcnt_q <= V_LAST;
            tick_q <= 1'b0;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
            act_q  <= 1'b0;
            posx_q <= '0;
            posy_q <= '0;
            hs_q   <= ~H_ON;
            vs_q   <= ~V_ON;
        end else begin
            div_q  <= div_d;
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            tick_q <= wrap;
            ls_q   <= wrap && (hcnt_d == '0);
            fs_q   <= wrap && (hcnt_d == '0) && (vcnt_d == '0);
            if (wrap) begin
                act_q  <= act_d;
                posx_q <= act_d ? hcnt_d : '0;
                posy_q <= act_d ? vcnt_d : '0;
                hs_q   <= hSync ? H_ON : ~H_ON;
                vs_q   <= vSync ? V_ON : ~V_ON;
            end
        end
    end

    assign PIX_TICK    = tick_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_ENABLE  = act_q;
    assign VGA_POS_X   = posx_q;
    assign VGA_POS_Y   = posy_q;
    assign LINE_START  = ls_q;
    assign FRAME_START = fs_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_generator
//
// Three generator instances share clock, reset and enable:
//   dDef : default 800x600 timing, CLK_DIV=2, active-high syncs
//   dSp  : tiny raster H 8/2/3/1, V 4/1/2/1, CLK_DIV=1, active-high syncs
//   dSn  : same tiny raster with active-low syncs
// Each test task resets the group and checks the instance it is about.
// ---------------------------------------------------------------------------
module tb_vga_timing_generator;

    logic clk = 1'b0;
    logic rstN;
    logic en;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    logic        dTick, dHs, dVs, dEn, dLs, dFs;
    logic [10:0] dX;
    logic [9:0]  dY;
    logic        pTick, pHs, pVs, pEn, pLs, pFs;
    logic [3:0]  pX;
    logic [2:0]  pY;
    logic        nTick, nHs, nVs, nEn, nLs, nFs;
    logic [3:0]  nX;
    logic [2:0]  nY;

    vga_timing_generator dDef (
        .CLK(clk), .RST_N(rstN), .EN(en),
        .PIX_TICK(dTick), .VGA_HS(dHs), .VGA_VS(dVs), .VGA_ENABLE(dEn),
        .VGA_POS_X(dX), .VGA_POS_Y(dY), .LINE_START(dLs), .FRAME_START(dFs)
    );

    vga_timing_generator #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1), .V_POL(1), .CLK_DIV(1), .XW(4), .YW(3)
    ) dSp (
        .CLK(clk), .RST_N(rstN), .EN(en),
        .PIX_TICK(pTick), .VGA_HS(pHs), .VGA_VS(pVs), .VGA_ENABLE(pEn),
        .VGA_POS_X(pX), .VGA_POS_Y(pY), .LINE_START(pLs), .FRAME_START(pFs)
    );

    vga_timing_generator #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(0), .V_POL(0), .CLK_DIV(1), .XW(4), .YW(3)
    ) dSn (
        .CLK(clk), .RST_N(rstN), .EN(en),
        .PIX_TICK(nTick), .VGA_HS(nHs), .VGA_VS(nVs), .VGA_ENABLE(nEn),
        .VGA_POS_X(nX), .VGA_POS_Y(nY), .LINE_START(nLs), .FRAME_START(nFs)
    );

    // Hold reset for two edges, then release on a falling edge so the next
    // rising edge is edge 1 after release.
    task automatic applyReset();
        rstN = 1'b0;
        en   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic releaseReset();
        @(negedge clk);
        rstN = 1'b1;
    endtask

    // Reset values on all three instances (no release).
    task automatic test_reset();
        applyReset();
        total++;
        if ({dTick, dHs, dVs, dEn, dLs, dFs} !== 6'b000000) begin
            bad++;
            $display("[TB] FAIL reset_def_flags got=%b want=000000", {dTick, dHs, dVs, dEn, dLs, dFs});
        end
        total++;
        if (dX !== 11'd0 || dY !== 10'd0) begin
            bad++;
            $display("[TB] FAIL reset_def_pos got=(%0d,%0d) want=(0,0)", dX, dY);
        end
        total++;
        if ({pTick, pHs, pVs, pEn, pLs, pFs, pX, pY} !== 13'd0) begin
            bad++;
            $display("[TB] FAIL reset_small got=%b want=0", {pTick, pHs, pVs, pEn, pLs, pFs, pX, pY});
        end
    endtask

    // First pixel tick of the default instance: none on edge 1, tick on
    // edge 2 at (0,0) with both strobes, strobes gone on edge 3.
    task automatic test_first_tick();
        releaseReset();
        @(posedge clk); #1;
        total++;
        if ({dTick, dLs, dFs, dEn} !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL first_edge1 got=%b want=0000", {dTick, dLs, dFs, dEn});
        end
        @(posedge clk); #1;
        total++;
        if ({dTick, dLs, dFs, dEn, dHs, dVs} !== 6'b111100) begin
            bad++;
            $display("[TB] FAIL first_edge2 got=%b want=111100", {dTick, dLs, dFs, dEn, dHs, dVs});
        end
        total++;
        if (dX !== 11'd0 || dY !== 10'd0) begin
            bad++;
            $display("[TB] FAIL first_pos got=(%0d,%0d) want=(0,0)", dX, dY);
        end
        @(posedge clk); #1;
        total++;
        if ({dTick, dLs, dFs, dEn} !== 4'b0001 || dX !== 11'd0) begin
            bad++;
            $display("[TB] FAIL first_edge3 got=%b x=%0d want=0001 x=0", {dTick, dLs, dFs, dEn}, dX);
        end
        @(posedge clk); #1;
        total++;
        if (dTick !== 1'b1 || dX !== 11'd1) begin
            bad++;
            $display("[TB] FAIL first_edge4 got tick=%b x=%0d want tick=1 x=1", dTick, dX);
        end
    endtask

    // Two frames of the tiny raster (active-high), every tick checked
    // against hand-derived windows, plus strobe spacing.
    task automatic test_small_timing();
        int h, v, lastLs, lastFs;
        logic [5:0] exp6;
        logic [3:0] ex;
        logic [2:0] ey;
        lastLs = -1;
        lastFs = -1;
        applyReset();
        releaseReset();
        for (int i = 0; i < 224; i++) begin
            @(posedge clk); #1;
            h = i % 14;
            v = (i / 14) % 8;
            exp6[5] = 1'b1;
            exp6[4] = (h >= 10 && h <= 12);
            exp6[3] = (v == 5 || v == 6);
            exp6[2] = (h < 8 && v < 4);
            exp6[1] = (h == 0);
            exp6[0] = (h == 0 && v == 0);
            ex = exp6[2] ? 4'(h) : 4'd0;
            ey = exp6[2] ? 3'(v) : 3'd0;
            total++;
            if ({pTick, pHs, pVs, pEn, pLs, pFs} !== exp6) begin
                bad++;
                $display("[TB] FAIL small_flags i=%0d got=%b want=%b", i, {pTick, pHs, pVs, pEn, pLs, pFs}, exp6);
            end
            total++;
            if (pX !== ex || pY !== ey) begin
                bad++;
                $display("[TB] FAIL small_pos i=%0d got=(%0d,%0d) want=(%0d,%0d)", i, pX, pY, ex, ey);
            end
            if (pLs === 1'b1) begin
                if (lastLs >= 0) begin
                    total++;
                    if (i - lastLs != 14) begin
                        bad++;
                        $display("[TB] FAIL small_line_period got=%0d want=14", i - lastLs);
                    end
                end
                lastLs = i;
            end
            if (pFs === 1'b1) begin
                if (lastFs >= 0) begin
                    total++;
                    if (i - lastFs != 112) begin
                        bad++;
                        $display("[TB] FAIL small_frame_period got=%0d want=112", i - lastFs);
                    end
                end
                lastFs = i;
            end
        end
        total++;
        if (lastFs != 112) begin
            bad++;
            $display("[TB] FAIL small_frame_seen got=%0d want=112", lastFs);
        end
    endtask

    // Active-low syncs: idle high in reset, low exactly in the same windows.
    task automatic test_polarity();
        int h, v;
        logic [1:0] exp2;
        applyReset();
        total++;
        if ({nHs, nVs} !== 2'b11) begin
            bad++;
            $display("[TB] FAIL pol_reset got=%b want=11", {nHs, nVs});
        end
        releaseReset();
        for (int i = 0; i < 112; i++) begin
            @(posedge clk); #1;
            h = i % 14;
            v = i / 14;
            exp2[1] = !(h >= 10 && h <= 12);
            exp2[0] = !(v == 5 || v == 6);
            total++;
            if ({nHs, nVs} !== exp2) begin
                bad++;
                $display("[TB] FAIL pol_sync i=%0d got=%b want=%b", i, {nHs, nVs}, exp2);
            end
        end
    endtask

    // EN low for 10 CLKs mid-line: tiny raster paused at (2,1), default
    // raster paused at x=7 with its divider half-way.
    task automatic test_enable_hold();
        applyReset();
        releaseReset();
        repeat (17) @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            total++;
            if ({pTick, pLs, pFs, pEn, pHs, pVs} !== 6'b000100 || pX !== 4'd2 || pY !== 3'd1) begin
                bad++;
                $display("[TB] FAIL hold_small k=%0d got=%b (%0d,%0d) want=000100 (2,1)", k, {pTick, pLs, pFs, pEn, pHs, pVs}, pX, pY);
            end
            total++;
            if (dTick !== 1'b0 || dX !== 11'd7 || dEn !== 1'b1) begin
                bad++;
                $display("[TB] FAIL hold_def k=%0d got tick=%b x=%0d en=%b want 0 7 1", k, dTick, dX, dEn);
            end
        end
        @(negedge clk);
        en = 1'b1;
        @(posedge clk); #1;
        total++;
        if (pTick !== 1'b1 || pX !== 4'd3 || pY !== 3'd1) begin
            bad++;
            $display("[TB] FAIL resume_small got tick=%b (%0d,%0d) want 1 (3,1)", pTick, pX, pY);
        end
        total++;
        if (dTick !== 1'b1 || dX !== 11'd8) begin
            bad++;
            $display("[TB] FAIL resume_def got tick=%b x=%0d want 1 8", dTick, dX);
        end
        @(posedge clk); #1;
        total++;
        if (dTick !== 1'b0 || pX !== 4'd4) begin
            bad++;
            $display("[TB] FAIL resume_next got dtick=%b px=%0d want 0 4", dTick, pX);
        end
    endtask

    // Asynchronous reset between edges, then the power-up sequence again.
    task automatic test_mid_reset();
        applyReset();
        releaseReset();
        repeat (30) @(posedge clk);
        #3;
        total++;
        if (pEn !== 1'b1 || pX !== 4'd1 || pY !== 3'd2) begin
            bad++;
            $display("[TB] FAIL midrst_pre got en=%b (%0d,%0d) want 1 (1,2)", pEn, pX, pY);
        end
        rstN = 1'b0;
        #1;
        total++;
        if ({pTick, pHs, pVs, pEn, pLs, pFs, pX, pY} !== 13'd0) begin
            bad++;
            $display("[TB] FAIL midrst_small got=%b want=0", {pTick, pHs, pVs, pEn, pLs, pFs, pX, pY});
        end
        total++;
        if ({dTick, dHs, dVs, dEn, dLs, dFs} !== 6'b000000 || dX !== 11'd0 || {nHs, nVs} !== 2'b11) begin
            bad++;
            $display("[TB] FAIL midrst_def got=%b x=%0d nsync=%b want=000000 x=0 nsync=11", {dTick, dHs, dVs, dEn, dLs, dFs}, dX, {nHs, nVs});
        end
        repeat (2) @(posedge clk);
        test_first_tick();
    endtask

    // Default 800x600 raster over two lines: tick spacing, visible edge,
    // HS window 840..967, line length 1056.
    task automatic test_defaults();
        int idx, lastE, hsCnt;
        idx   = 0;
        lastE = 0;
        hsCnt = 0;
        applyReset();
        releaseReset();
        for (int e = 1; e <= 4228; e++) begin
            @(posedge clk); #1;
            if (dTick === 1'b1) begin
                total++;
                if (e - lastE != 2) begin
                    bad++;
                    $display("[TB] FAIL def_tick_gap idx=%0d got=%0d want=2", idx, e - lastE);
                end
                lastE = e;
                if (idx < 1056 && dHs === 1'b1) hsCnt++;
                if (idx == 0 || idx == 1056) begin
                    total++;
                    if (dLs !== 1'b1 || dFs !== (idx == 0) || dEn !== 1'b1 || dX !== 11'd0 || dY !== 10'(idx / 1056)) begin
                        bad++;
                        $display("[TB] FAIL def_linestart idx=%0d got ls=%b fs=%b en=%b (%0d,%0d)", idx, dLs, dFs, dEn, dX, dY);
                    end
                end
                if (idx == 799 || idx == 800) begin
                    total++;
                    if (dEn !== (idx == 799) || dX !== ((idx == 799) ? 11'd799 : 11'd0)) begin
                        bad++;
                        $display("[TB] FAIL def_visible_edge idx=%0d got en=%b x=%0d", idx, dEn, dX);
                    end
                end
                if (idx == 839 || idx == 840 || idx == 967 || idx == 968) begin
                    total++;
                    if (dHs !== (idx == 840 || idx == 967)) begin
                        bad++;
                        $display("[TB] FAIL def_hs_edge idx=%0d got=%b", idx, dHs);
                    end
                end
                if (idx == 1055) begin
                    total++;
                    if (dLs !== 1'b0 || dVs !== 1'b0) begin
                        bad++;
                        $display("[TB] FAIL def_line_end got ls=%b vs=%b want 0 0", dLs, dVs);
                    end
                end
                idx++;
            end
        end
        total++;
        if (hsCnt != 128) begin
            bad++;
            $display("[TB] FAIL def_hs_width got=%0d want=128", hsCnt);
        end
        total++;
        if (idx != 2114) begin
            bad++;
            $display("[TB] FAIL def_tick_count got=%0d want=2114", idx);
        end
    endtask

    initial begin
        rstN = 1'b0;
        en   = 1'b1;
        $display("[TB] starting vga_timing_generator tests");
        test_reset();
        test_first_tick();
        test_small_timing();
        test_polarity();
        test_enable_hold();
        test_mid_reset();
        test_defaults();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
